aes128_cipher_iter: RTL and testbench

Iterative AES-128 encryption datapath that sits directly downstream of the combinational key expansion: it consumes the 11 flattened round keys and one 128-bit plaintext block and produces the ciphertext. It computes one round per clock, so a block takes 11 cycles, with a start/done handshake toward the I2C-side controller. Decryption is out of scope.

---
 rtl/aes128_cipher_iter_pkg.sv | 16 +
 rtl/aes128_cipher_iter_round.sv | 25 ++
 rtl/sbox.sv | 16 +
 rtl/aes128_cipher_iter.sv | 49 ++++
 tb/tb_aes128_cipher_iter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/aes128_cipher_iter_pkg.sv
// aes128_cipher_iter_pkg: shared AES-128 sizes, FSM encoding and GF(2^8) helpers
package aes128_cipher_iter_pkg;
  localparam int AES_NR   = 10;
  localparam int AES_BLK  = 128;
  localparam int AES_RK_W = 1408;
  typedef enum logic {S_IDLE, S_ROUND} fsm_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul2(input logic [7:0] b);
    return xtime(b);
  endfunction
  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction
endpackage

// File: rtl/aes128_cipher_iter_round.sv
// aes_round: one combinational AES encryption round; last skips MixColumns
module aes_round
  import aes128_cipher_iter_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] next
);
  logic [127:0] w_sb, w_sr, w_mc;
  for (genvar i = 0; i < 16; i++) begin : g_sb
    sbox u_sbox (.endereco(state[127-8*i -: 8]), .dado(w_sb[127-8*i -: 8]));
  end
  // byte k = 4*column + row; row r takes its byte from column (c+r) mod 4
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
      assign w_mc[127-8*(4*c+r) -: 8] = mul2(w_sr[127-8*(4*c+r) -: 8])
                                      ^ mul3(w_sr[127-8*(4*c+(r+1)%4) -: 8])
                                      ^ w_sr[127-8*(4*c+(r+2)%4) -: 8]
                                      ^ w_sr[127-8*(4*c+(r+3)%4) -: 8];
    end
  end
  assign next = (last ? w_sr : w_mc) ^ rk;
endmodule

// File: rtl/sbox.sv
// sbox: AES forward S-box lookup, byte 0 of the table in the MSBs
module sbox (
  input  logic [7:0] endereco,
  output logic [7:0] dado
);
  localparam logic [2047:0] TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign dado = TAB[{~endereco, 3'b000} +: 8];
endmodule

// File: rtl/aes128_cipher_iter.sv
// aes128_cipher_iter: iterative AES-128 encryption, one round per clock
module aes128_cipher_iter
  import aes128_cipher_iter_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AES_BLK-1:0]  plaintext,
  input  logic [AES_RK_W-1:0] round_key_flat,
  output logic [AES_BLK-1:0]  ciphertext,
  output logic                busy,
  output logic                done
);
  fsm_t         r_fsm, w_fsm_nxt;
  logic [3:0]   r_rnd, w_idx;
  logic [127:0] r_state, w_rk, w_next;
  logic         w_last, w_accept;
  always_comb begin
    w_accept  = (r_fsm == S_IDLE) && start;
    w_last    = (r_fsm == S_ROUND) && (r_rnd == 4'(NR));
    w_idx     = (r_fsm == S_ROUND) ? r_rnd : 4'd0;
    w_fsm_nxt = (r_fsm == S_IDLE) ? (start ? S_ROUND : S_IDLE) : (w_last ? S_IDLE : S_ROUND);
  end
  assign w_rk = round_key_flat[{w_idx, 7'd0} +: 128];
  aes_round u_round (.state(r_state), .rk(w_rk), .last(w_last), .next(w_next));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm      <= S_IDLE;
      r_rnd      <= '0;
      r_state    <= '0;
      ciphertext <= '0;
      done       <= 1'b0;
    end else begin
      r_fsm <= w_fsm_nxt;
      done  <= w_last;
      if (w_accept) begin
        r_state <= plaintext ^ w_rk;
        r_rnd   <= 4'd1;
      end else if (r_fsm == S_ROUND) begin
        r_state <= w_next;
        r_rnd   <= w_last ? r_rnd : r_rnd + 4'd1;
      end
      if (w_last) ciphertext <= w_next;
    end
  end
  assign busy = (r_fsm == S_ROUND);
endmodule

// File: tb/tb_aes128_cipher_iter.sv
// tb_aes128_cipher_iter: FIPS-197 vectors, handshake corner cases and random blocks
module tb_aes128_cipher_iter;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [127:0]  plaintext = '0;
  logic [1407:0] round_key_flat = '0;
  logic [127:0]  ciphertext;
  logic          busy, done;
  int            n_chk = 0, n_fail = 0;
  logic [7:0]    sb_tab [256];

  aes128_cipher_iter dut (
    .clk(clk), .rst(rst), .start(start), .plaintext(plaintext),
    .round_key_flat(round_key_flat), .ciphertext(ciphertext), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  function automatic logic [7:0] sbox_def(input logic [7:0] x);
    logic [7:0] inv, r;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    r = 8'h63;
    for (int i = 0; i < 8; i++)
      r[i] = r[i] ^ inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
    return r;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) o[j*128 +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return o;
  endfunction

  // state after nr rounds (nr=10 gives the ciphertext)
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] rkf, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k, o;
    k = rkf[127:0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rd != 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[4*c+r] = gmul(8'h02, s[4*c+r]) ^ gmul(8'h03, s[4*c+(r+1)%4])
                     ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      k = rkf[rd*128 +: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat counts edges from the accept edge (inclusive) to the one after which done is seen
  task automatic go(input logic [127:0] pt, input logic [1407:0] rkf, output int lat, output logic [127:0] st1);
    plaintext = pt; round_key_flat = rkf; start = 1'b1;
    tick();
    start = 1'b0; plaintext = ~pt; lat = 1; st1 = '0;
    while (!done && lat < 30) begin
      tick();
      lat++;
      if (lat == 2) st1 = dut.r_state;
    end
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  initial begin
    logic [1407:0] rk_c1, rk_b, rkf;
    logic [127:0]  st1, ct_hold, key, pt;
    int            lat, k, ndone, first;
    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_def(8'(i));
    rk_c1 = expand(C1_KEY);
    rk_b  = expand(B_KEY);
    repeat (3) tick();
    expect_eq("reset_ct", ciphertext, 128'h0);
    expect_eq("reset_busy", busy, 0);
    expect_eq("reset_done", done, 0);
    rst = 1'b0;
    tick();
    go(C1_PT, rk_c1, lat, st1);
    expect_eq("c1_latency", lat, 11);
    expect_eq("c1_ct", ciphertext, C1_CT);
    expect_eq("c1_busy_low_at_done", busy, 0);
    tick();
    expect_eq("c1_done_one_cycle", done, 0);
    go(B_PT, rk_b, lat, st1);
    expect_eq("b_round1_state", st1, B_R1);
    expect_eq("b_latency", lat, 11);
    expect_eq("b_ct", ciphertext, B_CT);
    tick();
    // start while busy must be ignored
    plaintext = C1_PT; round_key_flat = rk_c1; start = 1'b1;
    tick();
    start = 1'b0; ndone = 0; first = 0;
    for (int j = 1; j <= 20; j++) begin
      if (j == 5) begin start = 1'b1; plaintext = B_PT; end
      if (j == 6) start = 1'b0;
      tick();
      if (done) begin ndone++; if (first == 0) first = j + 1; end
      if (j == 3) expect_eq("busy_mid_block", busy, 1);
    end
    expect_eq("busy_start_done_count", ndone, 1);
    expect_eq("busy_start_latency", first, 11);
    expect_eq("busy_start_ct", ciphertext, C1_CT);
    // back-to-back: start held through the done cycle
    plaintext = C1_PT; round_key_flat = rk_c1; start = 1'b1;
    tick();
    k = 1;
    while (!done && k < 30) begin tick(); k++; end
    expect_eq("b2b_first_latency", k, 11);
    expect_eq("b2b_first_ct", ciphertext, C1_CT);
    plaintext = B_PT; round_key_flat = rk_b;
    tick();
    start = 1'b0;
    expect_eq("b2b_no_idle_busy", busy, 1);
    expect_eq("b2b_done_dropped", done, 0);
    lat = 1;
    while (!done && lat < 30) begin tick(); lat++; end
    expect_eq("b2b_second_latency", lat, 11);
    expect_eq("b2b_second_ct", ciphertext, B_CT);
    tick();
    // reset mid-block
    plaintext = C1_PT; round_key_flat = rk_c1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    expect_eq("rst_mid_ct", ciphertext, 128'h0);
    expect_eq("rst_mid_busy", busy, 0);
    expect_eq("rst_mid_done", done, 0);
    ndone = 0;
    repeat (6) begin tick(); ndone += int'(done); end
    expect_eq("rst_no_done_pulse", ndone, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    go(C1_PT, rk_c1, lat, st1);
    expect_eq("rst_restart_latency", lat, 11);
    expect_eq("rst_restart_ct", ciphertext, C1_CT);
    // hold behaviour
    ct_hold = ciphertext;
    for (int j = 0; j < 20; j++) begin
      tick();
      expect_eq("hold_ct", ciphertext, ct_hold);
      expect_eq("hold_busy_done", {busy, done}, 2'b00);
    end
    // random blocks against the reference model
    for (int j = 0; j < 10; j++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      rkf = expand(key);
      go(pt, rkf, lat, st1);
      expect_eq("rand_latency", lat, 11);
      expect_eq("rand_round1", st1, encrypt(pt, rkf, 1));
      expect_eq("rand_ct", ciphertext, encrypt(pt, rkf, 10));
      repeat ($urandom_range(0, 2)) tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
